// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter/sequencer for the shared AHB master port.
// Owners: RC4 engine, edge-detect writer (ED), source-image reader (SI).
// A grant is held for a whole run. MAX_BEATS bounds how long an owner keeps
// the port while another requester waits. Every owner change inserts one
// dead HANDOFF cycle.
module ahb_master_arbiter #(
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        rc4_req,
   input  logic        ed_req,
   input  logic        si_req,
   input  logic [31:0] rc4_wdata,
   input  logic [19:0] rc4_pixNum,
   input  logic [1:0]  rc4_mode,
   input  logic [15:0] ed_wdata,
   input  logic [19:0] ed_wpixNum,
   input  logic [19:0] si_rpixNum,
   input  logic [31:0] rdata,
   input  logic        data_feedback,
   output logic        rc4_gnt,
   output logic        ed_gnt,
   output logic        si_gnt,
   output logic [31:0] rc4_rdata,
   output logic [31:0] si_rdata,
   output logic        rc4_dfb,
   output logic        ed_dfb,
   output logic        si_dfb,
   output logic [1:0]  mode,
   output logic [19:0] pixNum,
   output logic [31:0] wdata,
   output logic [1:0]  size,
   output logic        startAddr_sel,
   output logic        busy
);

   typedef enum logic [2:0] {StIdle, StGrantRc4, StGrantEd, StGrantSi, StHandoff} state_e;

   localparam logic [1:0] OwnRc4 = 2'd0;
   localparam logic [1:0] OwnEd  = 2'd1;
   localparam logic [1:0] OwnSi  = 2'd2;

   state_e      state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic [7:0]  beats_q, beats_d;
   logic [8:0]  beats_inc;
   logic        own_req, other_req;
   logic [1:0]  cur_owner;

   // Next GRANT state when searching after the previous owner; the previous
   // owner comes last, so it only wins again when nobody else is asking.
   function automatic state_e rr_pick(input logic [1:0] last_owner, input logic [2:0] req);
      state_e pick;
      pick = StIdle;
      case (last_owner)
         OwnRc4: begin
            if (req[1])      pick = StGrantEd;
            else if (req[2]) pick = StGrantSi;
            else if (req[0]) pick = StGrantRc4;
         end
         OwnEd: begin
            if (req[2])      pick = StGrantSi;
            else if (req[0]) pick = StGrantRc4;
            else if (req[1]) pick = StGrantEd;
         end
         default: begin
            if (req[0])      pick = StGrantRc4;
            else if (req[1]) pick = StGrantEd;
            else if (req[2]) pick = StGrantSi;
         end
      endcase
      return pick;
   endfunction

   assign rc4_gnt = (state_q == StGrantRc4);
   assign ed_gnt  = (state_q == StGrantEd);
   assign si_gnt  = (state_q == StGrantSi);
   assign busy    = rc4_gnt | ed_gnt | si_gnt;

   // Beats and read data reach only the current owner; pulses outside a grant are dropped.
   assign rc4_dfb   = rc4_gnt & data_feedback;
   assign ed_dfb    = ed_gnt & data_feedback;
   assign si_dfb    = si_gnt & data_feedback;
   assign rc4_rdata = rc4_gnt ? rdata : 32'h0;
   assign si_rdata  = si_gnt ? rdata : 32'h0;

   assign cur_owner = ed_gnt ? OwnEd : (si_gnt ? OwnSi : OwnRc4);
   assign own_req   = (rc4_gnt & rc4_req) | (ed_gnt & ed_req) | (si_gnt & si_req);
   assign other_req = rc4_gnt ? (ed_req | si_req) :
                      ed_gnt  ? (rc4_req | si_req) : (rc4_req | ed_req);
   // Includes the pulse arriving this cycle so the budget check sees it.
   assign beats_inc = {1'b0, beats_q} + {8'h00, data_feedback};

   // State, last-owner pointer and beat counter registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StIdle;
         last_q  <= OwnSi;
         beats_q <= 8'h00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         beats_q <= beats_d;
      end
   end

   // Arbitration and grant release.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      beats_d = beats_q;
      unique case (state_q)
         StIdle, StHandoff: begin
            state_d = rr_pick(last_q, {si_req, ed_req, rc4_req});
         end
         StGrantRc4, StGrantEd, StGrantSi: begin
            if (!own_req || ((beats_inc >= 9'(MAX_BEATS)) && other_req)) begin
               state_d = StHandoff;
               last_d  = cur_owner;
               beats_d = 8'h00;
            end else if (beats_inc >= 9'(MAX_BEATS)) begin
               beats_d = 8'h00;
            end else begin
               beats_d = beats_inc[7:0];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Master-side signals driven from the registered owner.
   always_comb begin
      mode          = 2'b00;
      pixNum        = 20'h0;
      wdata         = 32'h0;
      size          = 2'b10;
      startAddr_sel = 1'b0;
      unique case (state_q)
         StGrantRc4: begin
            mode   = rc4_mode;
            pixNum = rc4_pixNum;
            wdata  = rc4_wdata;
         end
         StGrantEd: begin
            mode          = 2'b10;
            pixNum        = ed_wpixNum;
            wdata         = {16'h0000, ed_wdata};
            size          = 2'b01;
            startAddr_sel = 1'b1;
         end
         StGrantSi: begin
            mode   = 2'b01;
            pixNum = si_rpixNum;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter (instance built with MAX_BEATS=4).
module tb_ahb_master_arbiter;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        rc4_req, ed_req, si_req;
   logic [31:0] rc4_wdata;
   logic [19:0] rc4_pixNum;
   logic [1:0]  rc4_mode;
   logic [15:0] ed_wdata;
   logic [19:0] ed_wpixNum;
   logic [19:0] si_rpixNum;
   logic [31:0] rdata;
   logic        data_feedback;
   logic        rc4_gnt, ed_gnt, si_gnt;
   logic [31:0] rc4_rdata, si_rdata;
   logic        rc4_dfb, ed_dfb, si_dfb;
   logic [1:0]  mode;
   logic [19:0] pixNum;
   logic [31:0] wdata;
   logic [1:0]  size;
   logic        startAddr_sel;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ahb_master_arbiter #(.MAX_BEATS(4)) dut (
      .clk(clk), .n_rst(n_rst),
      .rc4_req(rc4_req), .ed_req(ed_req), .si_req(si_req),
      .rc4_wdata(rc4_wdata), .rc4_pixNum(rc4_pixNum), .rc4_mode(rc4_mode),
      .ed_wdata(ed_wdata), .ed_wpixNum(ed_wpixNum), .si_rpixNum(si_rpixNum),
      .rdata(rdata), .data_feedback(data_feedback),
      .rc4_gnt(rc4_gnt), .ed_gnt(ed_gnt), .si_gnt(si_gnt),
      .rc4_rdata(rc4_rdata), .si_rdata(si_rdata),
      .rc4_dfb(rc4_dfb), .ed_dfb(ed_dfb), .si_dfb(si_dfb),
      .mode(mode), .pixNum(pixNum), .wdata(wdata), .size(size),
      .startAddr_sel(startAddr_sel), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst = 1'b0; rc4_req = 1'b1; ed_req = 1'b1; si_req = 1'b1;
      tick(); tick();
      checks++; if ({rc4_gnt, ed_gnt, si_gnt} !== 3'b000) begin failures++; $display("FAIL reset_gnt: got %b want 000", {rc4_gnt, ed_gnt, si_gnt}); end
      checks++; if (mode !== 2'b00) begin failures++; $display("FAIL reset_mode: got %b want 00", mode); end
      checks++; if (size !== 2'b10) begin failures++; $display("FAIL reset_size: got %b want 10", size); end
      checks++; if (pixNum !== 20'h0) begin failures++; $display("FAIL reset_pixnum: got %h want 0", pixNum); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({wdata, startAddr_sel} !== 33'h0) begin failures++; $display("FAIL reset_wdata_sel: got %h want 0", {wdata, startAddr_sel}); end
      n_rst = 1'b1;
      tick();
      checks++; if ({rc4_gnt, ed_gnt, si_gnt, busy} !== 4'b1001) begin failures++; $display("FAIL reset_first_rc4: got %b want 1001", {rc4_gnt, ed_gnt, si_gnt, busy}); end
      rc4_req = 1'b0; ed_req = 1'b0; si_req = 1'b0;
      tick();
      checks++; if ({busy, mode} !== 3'b000) begin failures++; $display("FAIL reset_cleanup_handoff: got %b want 000", {busy, mode}); end
      tick();
   endtask

   task automatic test_rc4_solo();
      int pulses = 0;
      rc4_mode = 2'b10; rc4_pixNum = 20'h00123; rc4_wdata = 32'hDEADBEEF;
      rc4_req = 1'b1;
      tick();
      checks++; if ({rc4_gnt, busy, mode, size} !== 6'b111010) begin failures++; $display("FAIL rc4_grant: got %b want 111010", {rc4_gnt, busy, mode, size}); end
      checks++; if (pixNum !== 20'h00123) begin failures++; $display("FAIL rc4_pixnum: got %h want 00123", pixNum); end
      checks++; if (wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rc4_wdata: got %h want deadbeef", wdata); end
      for (int i = 0; i < 3; i++) begin
         data_feedback = 1'b1; rdata = 32'h1000 + i;
         #1;
         if (rc4_dfb === 1'b1) pulses++;
         checks++; if ({ed_dfb, si_dfb} !== 2'b00) begin failures++; $display("FAIL rc4_other_dfb: got %b want 00", {ed_dfb, si_dfb}); end
         checks++; if (rc4_rdata !== 32'h1000 + i) begin failures++; $display("FAIL rc4_rdata: got %h want %h", rc4_rdata, 32'h1000 + i); end
         tick();
         data_feedback = 1'b0;
         #1;
         checks++; if (rc4_dfb !== 1'b0) begin failures++; $display("FAIL rc4_dfb_low: got %b want 0", rc4_dfb); end
         tick();
      end
      checks++; if (pulses != 3) begin failures++; $display("FAIL rc4_pulse_count: got %0d want 3", pulses); end
      rc4_req = 1'b0;
      tick();
      checks++; if ({rc4_gnt, busy, mode} !== 4'b0000) begin failures++; $display("FAIL rc4_handoff: got %b want 0000", {rc4_gnt, busy, mode}); end
      tick();
      checks++; if ({rc4_gnt, ed_gnt, si_gnt, mode} !== 5'b00000) begin failures++; $display("FAIL rc4_idle: got %b want 00000", {rc4_gnt, ed_gnt, si_gnt, mode}); end
   endtask

   task automatic test_round_robin();
      n_rst = 1'b0;
      rc4_req = 1'b1; ed_req = 1'b1; si_req = 1'b1;
      tick();
      n_rst = 1'b1;
      tick();
      checks++; if ({rc4_gnt, ed_gnt, si_gnt} !== 3'b100) begin failures++; $display("FAIL rr_first_rc4: got %b want 100", {rc4_gnt, ed_gnt, si_gnt}); end
      data_feedback = 1'b1; tick(); tick();
      data_feedback = 1'b0; rc4_req = 1'b0;
      tick();
      checks++; if ({rc4_gnt, ed_gnt, si_gnt, mode} !== 5'b00000) begin failures++; $display("FAIL rr_handoff1: got %b want 00000", {rc4_gnt, ed_gnt, si_gnt, mode}); end
      tick();
      checks++; if ({rc4_gnt, ed_gnt, si_gnt} !== 3'b010) begin failures++; $display("FAIL rr_second_ed: got %b want 010", {rc4_gnt, ed_gnt, si_gnt}); end
      checks++; if ({mode, size, startAddr_sel} !== 5'b10011) begin failures++; $display("FAIL rr_ed_ctrl: got %b want 10011", {mode, size, startAddr_sel}); end
      checks++; if (wdata !== 32'h0000_A5C3) begin failures++; $display("FAIL rr_ed_wdata: got %h want 0000a5c3", wdata); end
      checks++; if (pixNum !== 20'h0BEEF) begin failures++; $display("FAIL rr_ed_pixnum: got %h want 0beef", pixNum); end
      data_feedback = 1'b1; tick(); tick();
      data_feedback = 1'b0; ed_req = 1'b0;
      tick();
      checks++; if ({rc4_gnt, ed_gnt, si_gnt, mode} !== 5'b00000) begin failures++; $display("FAIL rr_handoff2: got %b want 00000", {rc4_gnt, ed_gnt, si_gnt, mode}); end
      tick();
      checks++; if ({rc4_gnt, ed_gnt, si_gnt} !== 3'b001) begin failures++; $display("FAIL rr_third_si: got %b want 001", {rc4_gnt, ed_gnt, si_gnt}); end
      checks++; if ({mode, size, startAddr_sel} !== 5'b01100) begin failures++; $display("FAIL rr_si_ctrl: got %b want 01100", {mode, size, startAddr_sel}); end
      checks++; if ({pixNum, wdata} !== {20'h54321, 32'h0}) begin failures++; $display("FAIL rr_si_pix_wdata: got %h want %h", {pixNum, wdata}, {20'h54321, 32'h0}); end
      data_feedback = 1'b1; rdata = 32'hCAFEF00D;
      #1;
      checks++; if (si_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rr_si_rdata: got %h want cafef00d", si_rdata); end
      checks++; if ({rc4_rdata, rc4_dfb, ed_dfb, si_dfb} !== 35'h1) begin failures++; $display("FAIL rr_si_routing: got %h want 1", {rc4_rdata, rc4_dfb, ed_dfb, si_dfb}); end
      tick(); tick();
      data_feedback = 1'b0; si_req = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_handoff3: got %b want 0", busy); end
      tick();
   endtask

   task automatic test_beat_budget();
      ed_req = 1'b1;
      tick();
      checks++; if (ed_gnt !== 1'b1) begin failures++; $display("FAIL budget_ed_grant: got %b want 1", ed_gnt); end
      data_feedback = 1'b1; tick(); tick();
      si_req = 1'b1;
      tick();
      checks++; if (ed_gnt !== 1'b1) begin failures++; $display("FAIL budget_ed_after3: got %b want 1", ed_gnt); end
      checks++; if (ed_dfb !== 1'b1) begin failures++; $display("FAIL budget_ed_dfb4: got %b want 1", ed_dfb); end
      tick();
      data_feedback = 1'b0;
      #1;
      checks++; if ({ed_gnt, si_gnt, mode} !== 4'b0000) begin failures++; $display("FAIL budget_handoff: got %b want 0000", {ed_gnt, si_gnt, mode}); end
      tick();
      checks++; if ({ed_gnt, si_gnt} !== 2'b01) begin failures++; $display("FAIL budget_si_grant: got %b want 01", {ed_gnt, si_gnt}); end
      si_req = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL budget_handoff2: got %b want 0", busy); end
      tick();
      checks++; if ({ed_gnt, si_gnt} !== 2'b10) begin failures++; $display("FAIL budget_ed_regrant: got %b want 10", {ed_gnt, si_gnt}); end
      ed_req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_si_wrap();
      int pulses = 0;
      int dropped = 0;
      si_req = 1'b1;
      tick();
      checks++; if (si_gnt !== 1'b1) begin failures++; $display("FAIL wrap_si_grant: got %b want 1", si_gnt); end
      data_feedback = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (si_dfb === 1'b1) pulses++;
         tick();
         if (si_gnt !== 1'b1) dropped++;
      end
      data_feedback = 1'b0;
      checks++; if (pulses != 10) begin failures++; $display("FAIL wrap_si_pulses: got %0d want 10", pulses); end
      checks++; if (dropped != 0) begin failures++; $display("FAIL wrap_si_drops: got %0d want 0", dropped); end
      si_req = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_mid_grant();
      int kept = 0;
      ed_req = 1'b1;
      tick();
      checks++; if (ed_gnt !== 1'b1) begin failures++; $display("FAIL arst_ed_grant: got %b want 1", ed_gnt); end
      data_feedback = 1'b1;
      tick();
      #1;
      checks++; if (ed_dfb !== 1'b1) begin failures++; $display("FAIL arst_ed_dfb_pre: got %b want 1", ed_dfb); end
      n_rst = 1'b0;
      #1;
      checks++; if ({ed_gnt, ed_dfb, startAddr_sel, size} !== 5'b00010) begin failures++; $display("FAIL arst_async_drop: got %b want 00010", {ed_gnt, ed_dfb, startAddr_sel, size}); end
      data_feedback = 1'b0;
      tick();
      n_rst = 1'b1;
      tick();
      checks++; if (ed_gnt !== 1'b1) begin failures++; $display("FAIL arst_ed_regrant: got %b want 1", ed_gnt); end
      // With beats back at 0, ED survives exactly three pulses while SI waits.
      si_req = 1'b1; data_feedback = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ed_gnt === 1'b1) kept++;
      end
      checks++; if (kept != 3) begin failures++; $display("FAIL arst_beats_cleared: got %0d want 3", kept); end
      tick();
      checks++; if (ed_gnt !== 1'b0) begin failures++; $display("FAIL arst_budget_release: got %b want 0", ed_gnt); end
      data_feedback = 1'b0; ed_req = 1'b0; si_req = 1'b0;
      tick(); tick(); tick();
   endtask

   initial begin
      n_rst = 1'b0; rc4_req = 1'b0; ed_req = 1'b0; si_req = 1'b0;
      rc4_wdata = 32'h0; rc4_pixNum = 20'h0; rc4_mode = 2'b10;
      ed_wdata = 16'hA5C3; ed_wpixNum = 20'h0BEEF; si_rpixNum = 20'h54321;
      rdata = 32'h0; data_feedback = 1'b0;
      test_reset();
      test_rc4_solo();
      test_round_robin();
      test_beat_budget();
      test_si_wrap();
      test_reset_mid_grant();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Registered arbiter and sequencer for the single shared AHB master port, shared by three requesters: RC4 cipher engine (read/write, word), edge-detect writer (ED, halfword write) and source-image reader (SI, word read). It replaces purely combinational requester selection with round-robin grants held for a whole transfer run, a bounded per-grant beat budget and a one-cycle dead handoff between owners. It sits between the requesters and the AHB master, driving the master's mode, pixNum, wdata, size and startAddr_sel, and routing rdata and data_feedback back to the owning requester only.

## Interface
- MAX_BEATS, 16, beats (data_feedback pulses) per grant before forced re-arbitration when another requester is waiting; legal range 1..255
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- rc4_req, ed_req, si_req  in  1 each  level request, held for the whole run
- rc4_wdata  in  32  RC4 write data
- rc4_pixNum  in  20  RC4 pixel index
- rc4_mode  in  2  RC4 transfer mode (01 read, 10 write)
- ed_wdata  in  16  ED write data
- ed_wpixNum  in  20  ED write pixel index
- si_rpixNum  in  20  SI read pixel index
- rdata  in  32  read data from master
- data_feedback  in  1  one-cycle beat-complete pulse from master
- rc4_gnt, ed_gnt, si_gnt  out  1 each  registered grant, one-hot or all zero
- rc4_rdata, si_rdata  out  32 each  rdata when owner, else 0
- rc4_dfb, ed_dfb, si_dfb  out  1 each  data_feedback when owner, else 0
- mode  out  2  to master; 00 no transfer
- pixNum  out  20  to master
- wdata  out  32  to master
- size  out  2  01 halfword, 10 word
- startAddr_sel  out  1  1 selects ED output buffer base address
- busy  out  1  high in any GRANT state

## Operation
- States: IDLE, GRANT_RC4, GRANT_ED, GRANT_SI, HANDOFF. 2-bit last-owner pointer `last`, 8-bit beat counter `beats`.
- Round-robin order RC4 -> ED -> SI -> RC4; search starts at requester after `last`.
- IDLE: if any req, go to GRANT of round-robin winner; else stay.
- GRANT_x: data_feedback increments `beats`.
  - If req_x is low, go to HANDOFF.
  - Else if `beats`+incoming pulse reaches MAX_BEATS and another req is high, go to HANDOFF.
  - Else if `beats` reaches MAX_BEATS with no other req, clear `beats` and hold GRANT_x.
- Entering HANDOFF: `last` <= x, `beats` <= 0.
- HANDOFF: arbitrate as IDLE, but never re-enter the same GRANT in zero cycles. The next state is the GRANT of the round-robin winner, or IDLE if no req.
- Output muxing, combinational from registered state:
  - GRANT_RC4: mode=rc4_mode, pixNum=rc4_pixNum, wdata=rc4_wdata, size=10, startAddr_sel=0.
  - GRANT_ED: mode=10, pixNum=ed_wpixNum, wdata={16'h0000, ed_wdata}, size=01, startAddr_sel=1.
  - GRANT_SI: mode=01, pixNum=si_rpixNum, wdata=0, size=10, startAddr_sel=0.
  - IDLE/HANDOFF: mode=00, pixNum=0, wdata=0, size=10, startAddr_sel=0.
- Feedback routing: dfb and rdata go only to the current owner (ED has no rdata output). data_feedback in IDLE/HANDOFF is dropped and does not count.
- Reset (n_rst low, any time, including mid-grant): state IDLE, `last`=SI so RC4 wins first, `beats`=0. All gnt, dfb and rdata outputs 0; mode 00; pixNum 0; wdata 0; size 10; startAddr_sel 0; busy 0. An in-flight beat is abandoned.

## Timing
- Request to grant: req high at edge k in IDLE/HANDOFF -> gnt high and mode valid from edge k (one cycle after req first driven).
- Release: req_x low sampled at edge k -> gnt_x low after edge k, HANDOFF for exactly one cycle, next gnt earliest after edge k+1.
- A data_feedback pulse coincident with the req_x drop is still routed and counted; release follows.
- Owner change always costs exactly one dead cycle (mode 00).
- Simultaneous requests resolve by round robin only, with no fixed priority beyond reset state.

## Test plan
- Reset: hold n_rst low with all reqs high -> all gnt 0, mode 00, size 10, pixNum 0, busy 0. Release -> rc4_gnt=1 next edge.
- RC4 solo, rc4_mode=10, rc4_pixNum=20'h00123, 3 data_feedback pulses -> mode=10, pixNum=00123, rc4_dfb pulses=3, ed_dfb/si_dfb stay 0. Drop req -> one cycle mode 00, then IDLE.
- All three reqs high from reset, each drops after 2 beats -> grant order RC4, ED, SI, one HANDOFF cycle between each. During ED: size=01, startAddr_sel=1, wdata={16'h0, ed_wdata}. During SI: mode=01, si_rdata=rdata.
- MAX_BEATS=4, ED holding, SI requests at ED beat 2 -> ED loses grant after its 4th pulse, HANDOFF, si_gnt=1. ED still requesting -> regains grant after SI releases.
- MAX_BEATS=4, SI alone for 10 beats -> si_gnt never drops, si_dfb pulses=10.
- Assert n_rst low mid-GRANT_ED with data_feedback high -> ed_gnt, ed_dfb and startAddr_sel drop immediately (asynchronous). After release with only ED requesting, ED is re-granted with `beats`=0.
